casper_tx_pkt_fifo: RTL and testbench
=====================================

# casper_tx_pkt_fifo

Store-and-forward packet FIFO between the CASPER TX AXI-Stream source and the 400G segmented-AXIS adapter that drives the DCMAC. The DCMAC forbids idle gaps inside a packet, so this block releases a packet only after its last beat is stored, then streams it without bubbles. Packets that are oversize, flagged bad, or do not fit are dropped whole. The input side never back-pressures.

## Interface
Parameters:
- DATA_WIDTH, 1024, tdata width in bits.
- KEEP_WIDTH, 128, tkeep width; always DATA_WIDTH/8.
- DEPTH_LOG2, 7, FIFO depth is 2^DEPTH_LOG2 beats (128 beats, 16 KiB).
- MAX_PKT_BEATS, 72, longest packet accepted, in beats (9216 B). Must be ≤ 2^DEPTH_LOG2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  CASPER TX data.
- s_tkeep  in  KEEP_WIDTH  byte enables.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  last beat of packet.
- s_tuser  in  1  bad-packet flag, sampled on the tlast beat.
- s_tready  out  1  constant 1.
- m_tdata  out  DATA_WIDTH  data to the adapter.
- m_tkeep  out  KEEP_WIDTH  stored tkeep.
- m_tvalid  out  1  output beat valid.
- m_tlast  out  1  stored tlast.
- m_tuser  out  1  constant 0.
- m_tready  in  1  adapter ready.
- stat_pkt_cnt  out  32  number of packets committed.
- stat_drop_cnt  out  32  number of packets dropped.
- fill_level  out  DEPTH_LOG2+1  number of occupied beats, committed plus in-flight.

## Operation
- Storage: simple dual-port RAM, one word per beat holding {tlast, tkeep, tdata}.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each DEPTH_LOG2+1 bits with an extra wrap bit.
  - Full: wr_ptr − rd_ptr == 2^DEPTH_LOG2.
  - Packets available: commit_ptr ≠ rd_ptr.
- Write state machine:
  - IDLE: a valid beat starts a packet and moves to WRITE, or stays in IDLE if it is a single-beat packet.
  - WRITE: store each valid beat and increment wr_ptr and the beat count.
  - On the tlast beat:
    - s_tuser=0: commit_ptr ← wr_ptr+1 and stat_pkt_cnt increments.
    - s_tuser=1: wr_ptr ← commit_ptr and stat_drop_cnt increments.
    - In both cases return to IDLE.
  - DROP: discard beats. On the tlast beat, wr_ptr ← commit_ptr, stat_drop_cnt increments, and return to IDLE.
- Entry to DROP happens on any beat that arrives while the FIFO is full, or when the beat count would exceed MAX_PKT_BEATS. The offending beat is not written. A tlast beat that triggers a drop takes the DROP tlast action in the same cycle.
- The full test uses the registered rd_ptr, so it is conservative by one cycle.
- Read side: a prefetch path (RAM output register plus a 2-entry skid) presents beats whenever packets are available.
  - Throughput is one beat per cycle while m_tready=1.
  - There are no bubbles inside a packet.
  - m_tvalid, once high, holds with stable data until m_tready=1 (AXI rule).
- Simultaneous commit and read: both take effect in the same cycle with no lost beats.
- Counters wrap modulo 2^32.
- The first beat accepted after reset is treated as start of packet.

## Timing
- Reset values: all pointers 0, write state IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, counters 0, fill_level=0.
- Reset mid-packet discards all stored and partial data immediately.
- Latency: tlast accepted in cycle N with the FIFO empty and m_tready=1 gives the first m_tvalid in cycle N+2.
- Back-to-back committed packets are output with zero idle cycles between them.
- fill_level updates one cycle after the write or read that changes it.

## Configuration
- TX_PKT_FIFO_STATS_EN defined: stat_pkt_cnt and stat_drop_cnt are live counters.
- Not defined: both counter outputs are tied to 0 and the counters are not synthesized. Drop behaviour is unchanged either way.

## Structure
- Shared package holds:
  - DATA_WIDTH and KEEP_WIDTH defaults.
  - The stored-word struct {last, keep, data}.
  - The write-state enum {IDLE, WRITE, DROP}.
- One sub-module, casper_tx_pkt_ram: parameterised simple dual-port RAM with registered read. Inferred as URAM.

## Test plan
- Single packet: 4 beats with tkeep all-ones, last beat tkeep=0x0000_FFFF, m_tready=1. Expect m_tvalid starting at N+2, 4 contiguous beats, data and keep identical, stat_pkt_cnt=1.
- Bad packet: 3-beat packet with s_tuser=1 on tlast. Expect no output, stat_drop_cnt=1, fill_level returns to 0.
- Oversize: 73-beat packet followed by a 2-beat packet. Expect only the 2-beat packet output, drop_cnt=1, pkt_cnt=1.
- Overflow: m_tready=0, write two 72-beat packets. Expect the first committed (fill_level=72) and the second dropped. Then m_tready=1: exactly 72 beats out.
- Backpressure: m_tready toggled randomly over 20 back-to-back 2-beat packets. Expect beat order preserved and data held stable while stalled.
- Reset mid-packet: rst for 1 cycle after 2 beats of a 5-beat packet. Expect all outputs at reset values, no output from that packet, fill_level=0.

Source files
------------

// File: rtl/casper_tx_pkt_fifo_pkg.sv
// Shared types for the CASPER TX store-and-forward packet FIFO: default bus
// widths, the stored RAM word layout and the write-side state encoding.
package casper_tx_pkt_fifo_pkg;

  localparam int TX_DATA_WIDTH = 1024;
  localparam int TX_KEEP_WIDTH = TX_DATA_WIDTH / 8;

  typedef struct packed {
    logic                     last;
    logic [TX_KEEP_WIDTH-1:0] keep;
    logic [TX_DATA_WIDTH-1:0] data;
  } tx_word_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/casper_tx_pkt_ram.sv
// Simple dual-port beat store with a registered, enabled read port.
// A read of the address being written in the same cycle returns the new word.
module casper_tx_pkt_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  (* ram_style = "ultra" *) logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  // Write port plus read register; the read register holds while re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/casper_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO: packets are released only once fully stored,
// then streamed gap-free. Define TX_PKT_FIFO_STATS_EN for live packet/drop counters.
module casper_tx_pkt_fifo
  import casper_tx_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = TX_DATA_WIDTH,
  parameter int KEEP_WIDTH    = TX_KEEP_WIDTH,
  parameter int DEPTH_LOG2    = 7,
  parameter int MAX_PKT_BEATS = 72
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  m_tready,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_drop_cnt,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int CW = DEPTH_LOG2 + 2;
  localparam int WW = 1 + KEEP_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] DEPTH_V = PW'(2 ** DEPTH_LOG2);
  localparam logic [CW-1:0] MAX_V   = CW'(MAX_PKT_BEATS);

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, cnt_next_s;
  logic          fifo_full_s, ram_we_s, commit_evt_s, drop_evt_s;
  logic          ram_re_s, rd_vld_q, rd_vld_d, pop_s, move_s;
  logic [WW-1:0] ram_rdata_s, out_q, out_d, spare_q, spare_d;
  logic          out_vld_q, out_vld_d, spare_vld_q, spare_vld_d;

  // rd_ptr only moves on output handshakes, so the full test is conservative.
  assign fifo_full_s = ((wr_ptr_q - rd_ptr_q) == DEPTH_V);
  assign pop_s       = out_vld_q & m_tready;

  // Write FSM: store, commit or discard whole packets.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    ram_we_s     = 1'b0;
    commit_evt_s = 1'b0;
    drop_evt_s   = 1'b0;
    cnt_next_s   = (state_q == WR_IDLE) ? CW'(1) : (beat_cnt_q + CW'(1));
    if (s_tvalid) begin
      case (state_q)
        WR_IDLE, WR_WRITE: begin
          if (fifo_full_s || (cnt_next_s > MAX_V)) begin
            if (s_tlast) begin
              wr_ptr_d   = commit_ptr_q;
              drop_evt_s = 1'b1;
              beat_cnt_d = CW'(0);
              state_d    = WR_IDLE;
            end else begin
              state_d = WR_DROP;
            end
          end else if (s_tlast) begin
            beat_cnt_d = CW'(0);
            state_d    = WR_IDLE;
            if (s_tuser) begin
              wr_ptr_d   = commit_ptr_q;
              drop_evt_s = 1'b1;
            end else begin
              ram_we_s     = 1'b1;
              wr_ptr_d     = wr_ptr_q + PW'(1);
              commit_ptr_d = wr_ptr_q + PW'(1);
              commit_evt_s = 1'b1;
            end
          end else begin
            ram_we_s   = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            beat_cnt_d = cnt_next_s;
            state_d    = WR_WRITE;
          end
        end
        WR_DROP: begin
          if (s_tlast) begin
            wr_ptr_d   = commit_ptr_q;
            drop_evt_s = 1'b1;
            beat_cnt_d = CW'(0);
            state_d    = WR_IDLE;
          end else begin
            state_d = WR_DROP;
          end
        end
        default: begin
          wr_ptr_d   = commit_ptr_q;
          beat_cnt_d = CW'(0);
          state_d    = WR_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Read side: RAM register feeds a 2-slot queue whose head is the output register.
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q & ~pop_s;
    spare_d     = spare_q;
    spare_vld_d = spare_vld_q;
    if (!out_vld_d) begin
      out_d       = spare_q;
      out_vld_d   = spare_vld_q;
      spare_vld_d = 1'b0;
    end else begin
      spare_vld_d = spare_vld_q;
    end
    move_s = rd_vld_q & ~(out_vld_d & spare_vld_d);
    if (move_s) begin
      if (!out_vld_d) begin
        out_d     = ram_rdata_s;
        out_vld_d = 1'b1;
      end else begin
        spare_d     = ram_rdata_s;
        spare_vld_d = 1'b1;
      end
    end else begin
      spare_d = spare_d;
    end
    // commit_ptr_d lets a packet committed this cycle be fetched at once.
    ram_re_s    = (fetch_ptr_q != commit_ptr_d) & (~rd_vld_q | move_s);
    rd_vld_d    = ram_re_s | (rd_vld_q & ~move_s);
    fetch_ptr_d = fetch_ptr_q + PW'(ram_re_s);
    rd_ptr_d    = rd_ptr_q + PW'(pop_s);
  end

  assign fill_d = wr_ptr_d - rd_ptr_d;

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= PW'(0);
      commit_ptr_q <= PW'(0);
      rd_ptr_q     <= PW'(0);
      fetch_ptr_q  <= PW'(0);
      fill_q       <= PW'(0);
      beat_cnt_q   <= CW'(0);
      rd_vld_q     <= 1'b0;
      out_q        <= WW'(0);
      out_vld_q    <= 1'b0;
      spare_q      <= WW'(0);
      spare_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      fill_q       <= fill_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_vld_q     <= rd_vld_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      spare_q      <= spare_d;
      spare_vld_q  <= spare_vld_d;
    end
  end

  casper_tx_pkt_ram #(
    .WIDTH  (WW),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata ({s_tlast, s_tkeep, s_tdata}),
    .re    (ram_re_s),
    .raddr (fetch_ptr_q[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata_s)
  );

  assign s_tready   = 1'b1;
  assign m_tuser    = 1'b0;
  assign m_tvalid   = out_vld_q;
  assign m_tlast    = out_q[WW-1];
  assign m_tkeep    = out_q[WW-2 -: KEEP_WIDTH];
  assign m_tdata    = out_q[DATA_WIDTH-1:0];
  assign fill_level = fill_q;

`ifdef TX_PKT_FIFO_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

  // Free-running event counters, wrapping modulo 2^32.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + 32'(commit_evt_s);
    drop_cnt_d = drop_cnt_q + 32'(drop_evt_s);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  logic stats_unused_s;
  assign stats_unused_s = commit_evt_s ^ drop_evt_s;
  assign stat_pkt_cnt   = 32'd0;
  assign stat_drop_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_casper_tx_pkt_fifo.sv
// Directed-plus-random bench for casper_tx_pkt_fifo; expected beats come from a
// packet-level queue model that drops bad, oversize and non-fitting packets.
module tb_casper_tx_pkt_fifo;

  localparam int DW    = 1024;
  localparam int KW    = 128;
  localparam int DL    = 7;
  localparam int MAXB  = 72;
  localparam int DEPTH = 128;
  localparam int WW    = 1 + KW + DW;
`ifdef TX_PKT_FIFO_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tlast, s_tuser, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tuser, m_tready;
  logic [31:0]   stat_pkt_cnt, stat_drop_cnt;
  logic [DL:0]   fill_level;

  casper_tx_pkt_fifo #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WW-1:0] exp_q[$];
  int tests = 0, fails = 0;
  int pushed_cnt = 0, popped_cnt = 0, exp_pkt = 0, exp_drop = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed last=%0b low128=%032h expected last=%0b low128=%032h",
             tag, obs[WW-1], obs[127:0], exp[WW-1], exp[127:0]);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
    return STATS_EN ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] rnd_keep();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  // Sends one packet back-to-back; the model decides commit or drop from packet rules.
  task automatic send_pkt(input int len, input bit bad, input logic [KW-1:0] last_keep,
                          output int tl_cyc);
    logic [WW-1:0] pkt[$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    tl_cyc = 0;
    for (int i = 0; i < len; i++) begin
      d        = rnd_data();
      k        = (i == len - 1) ? last_keep : {KW{1'b1}};
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = (i == len - 1);
      s_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      s_tvalid = 1'b1;
      pkt.push_back({s_tlast, k, d});
      if (i == len - 1) tl_cyc = cyc;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (!bad && len <= MAXB && (pushed_cnt - popped_cnt) + len <= DEPTH) begin
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
      pushed_cnt += len;
      exp_pkt++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: order, hold-while-stalled and no gaps inside a packet.
  bit            in_pkt = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [WW-1:0] prev_word;
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk_w("hold_data", {m_tlast, m_tkeep, m_tdata}, prev_word);
      end
      if (in_pkt) chk("no_bubble", 64'(m_tvalid), 64'd1);
      if (m_tvalid && m_tready) begin
        chk("spurious_beat", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk_w("beat", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
          popped_cnt++;
        end
        in_pkt = !m_tlast;
      end
      prev_v    = m_tvalid;
      prev_r    = m_tready;
      prev_word = {m_tlast, m_tkeep, m_tdata};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl;
    int cnt;
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tkeep_lo", m_tkeep[63:0], 64'd0);
    chk_w("rst_m_word", {m_tlast, m_tkeep, m_tdata}, {WW{1'b0}});
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(stat_drop_cnt), 64'd0);
    chk("s_tready", 64'(s_tready), 64'd1);
    chk("m_tuser", 64'(m_tuser), 64'd0);
    rst = 1'b0;
    tick();

    // Single 4-beat packet: first valid two cycles after tlast.
    send_pkt(4, 1'b0, 128'h0000_FFFF, tl);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_tvalid) break;
    end
    chk("latency", 64'(cyc - tl), 64'd2);
    wait_drain(50);
    chk("single_pkt_cnt", 64'(stat_pkt_cnt), 64'(stat_exp(exp_pkt)));

    // Bad packet is dropped whole.
    send_pkt(3, 1'b1, rnd_keep(), tl);
    repeat (10) tick();
    chk("bad_fill", 64'(fill_level), 64'd0);
    chk("bad_drop_cnt", 64'(stat_drop_cnt), 64'(stat_exp(exp_drop)));

    // Oversize followed immediately by a good 2-beat packet.
    send_pkt(MAXB + 1, 1'b0, rnd_keep(), tl);
    send_pkt(2, 1'b0, rnd_keep(), tl);
    wait_drain(50);
    chk("over_pkt_cnt", 64'(stat_pkt_cnt), 64'(stat_exp(exp_pkt)));
    chk("over_drop_cnt", 64'(stat_drop_cnt), 64'(stat_exp(exp_drop)));

    // Overflow: two max packets with the output stalled.
    m_tready = 1'b0;
    send_pkt(MAXB, 1'b0, rnd_keep(), tl);
    send_pkt(MAXB, 1'b0, rnd_keep(), tl);
    repeat (3) tick();
    chk("ovf_fill", 64'(fill_level), 64'(pushed_cnt - popped_cnt));
    chk("ovf_drop_cnt", 64'(stat_drop_cnt), 64'(stat_exp(exp_drop)));
    m_tready = 1'b1;
    wait_drain(200);
    chk("ovf_fill_after", 64'(fill_level), 64'd0);

    // Back-to-back committed packets stream with no idle cycle between them.
    m_tready = 1'b0;
    send_pkt(3, 1'b0, rnd_keep(), tl);
    send_pkt(1, 1'b0, rnd_keep(), tl);
    send_pkt(4, 1'b0, rnd_keep(), tl);
    repeat (3) tick();
    m_tready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_tvalid) cnt++;
    end
    chk("b2b_valid_run", 64'(cnt), 64'd8);
    wait_drain(50);

    // Random backpressure over 20 back-to-back 2-beat packets.
    rand_rdy = 1'b1;
    for (int p = 0; p < 20; p++) send_pkt(2, 1'b0, rnd_keep(), tl);
    wait_drain(400);

    // Random lengths, random bad flags, random gaps.
    for (int p = 0; p < 12; p++) begin
      send_pkt($urandom_range(1, 8), ($urandom_range(0, 4) == 0), rnd_keep(), tl);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain(400);
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    chk("rand_pkt_cnt", 64'(stat_pkt_cnt), 64'(stat_exp(exp_pkt)));
    chk("rand_drop_cnt", 64'(stat_drop_cnt), 64'(stat_exp(exp_drop)));
    chk("rand_fill", 64'(fill_level), 64'd0);

    // Reset after two beats of a five-beat packet.
    for (int i = 0; i < 2; i++) begin
      s_tdata = rnd_data(); s_tkeep = {KW{1'b1}}; s_tlast = 1'b0; s_tuser = 1'b0;
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    pushed_cnt = popped_cnt;
    exp_pkt = 0;
    exp_drop = 0;
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk_w("mid_rst_m_word", {m_tlast, m_tkeep, m_tdata}, {WW{1'b0}});
    chk("mid_rst_fill", 64'(fill_level), 64'd0);
    chk("mid_rst_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_fill", 64'(fill_level), 64'd0);
    send_pkt(3, 1'b0, rnd_keep(), tl);
    wait_drain(50);
    chk("post_rst_pkt_cnt", 64'(stat_pkt_cnt), 64'(stat_exp(exp_pkt)));
    chk("post_rst_drop_cnt", 64'(stat_drop_cnt), 64'(stat_exp(exp_drop)));
    chk("final_fill", 64'(fill_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
